// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus bundle: instruction handshake, register-file load port,
// ALU operand/result wires and the write-back result handshake.
interface alu_issue_stage_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [2:0]   in_dst;
    logic [2:0]   in_src1;
    logic [2:0]   in_src2;
    logic         ld_en;
    logic [2:0]   ld_addr;
    logic [W-1:0] ld_data;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [1:0]   alu_s;
    logic [W-1:0] alu_out;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic [2:0]   res_dst;

    modport master (
        output in_valid, in_op, in_dst, in_src1, in_src2,
        output ld_en, ld_addr, ld_data, alu_out, res_ready,
        input  in_ready, alu_a, alu_b, alu_s, res_valid, res_data, res_dst
    );

    modport slave (
        input  in_valid, in_op, in_dst, in_src1, in_src2,
        input  ld_en, ld_addr, ld_data, alu_out, res_ready,
        output in_ready, alu_a, alu_b, alu_s, res_valid, res_data, res_dst
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Operand-issue (EX) and write-back (WB) stage feeding a 16-bit ALU with an 8-entry RF.
// Define ALU_ISSUE_BYPASS_EN to forward alu_out into the operand mux; otherwise RAW hazards stall.
module alu_issue_stage #(
    parameter int NREG = 8,
    parameter int W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_stage_if.slave bus
);
    localparam int AW = 3;

    logic [W-1:0]         rf [NREG];
    logic                 ex_valid;
    logic [AW-1:0]        ex_dst;
    logic [W-1:0]         ex_a;
    logic [W-1:0]         ex_b;
    logic [1:0]           ex_s;
    logic                 wb_valid;
    logic [W-1:0]         wb_data;
    logic [AW-1:0]        wb_dst;

    logic                 wb_free;
    logic                 ex_adv;
    logic                 raw_stall;
    logic                 accept;
    logic [1:0][AW-1:0]   src;
    logic [1:0][W-1:0]    opnd;

    assign wb_free = !wb_valid || bus.res_ready;
    assign ex_adv  = ex_valid && wb_free;

`ifdef ALU_ISSUE_BYPASS_EN
    assign raw_stall = 1'b0;
`else
    // Without forwarding, a consumer waits until its producer has written the RF.
    assign raw_stall = ex_valid && (ex_dst == bus.in_src1 || ex_dst == bus.in_src2);
`endif

    assign bus.in_ready = rst_n && (!ex_valid || ex_adv) && !raw_stall;
    assign accept       = bus.in_valid && bus.in_ready;

    assign src[0] = bus.in_src1;
    assign src[1] = bus.in_src2;

    // Later assignments take priority: RF < ld_data < in-flight ALU result.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            opnd[k] = rf[src[k]];
            if (bus.ld_en && bus.ld_addr == src[k])
                opnd[k] = bus.ld_data;
`ifdef ALU_ISSUE_BYPASS_EN
            if (ex_adv && ex_dst == src[k])
                opnd[k] = bus.alu_out;
`endif
        end
    end

    // Pipeline write is last so it beats a colliding ld_en write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf <= '{default: '0};
        end else begin
            if (bus.ld_en)
                rf[bus.ld_addr] <= bus.ld_data;
            if (ex_adv)
                rf[ex_dst] <= bus.alu_out;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_dst   <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_s     <= '0;
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_dst   <= '0;
        end else begin
            // Operands hold (not zeroed) when EX drains, keeping ALU inputs quiet.
            if (accept) begin
                ex_valid <= 1'b1;
                ex_dst   <= bus.in_dst;
                ex_a     <= opnd[0];
                ex_b     <= opnd[1];
                ex_s     <= bus.in_op;
            end else if (ex_adv) begin
                ex_valid <= 1'b0;
            end

            if (ex_adv) begin
                wb_valid <= 1'b1;
                wb_data  <= bus.alu_out;
                wb_dst   <= ex_dst;
            end else if (bus.res_ready) begin
                wb_valid <= 1'b0;
            end
        end
    end

    assign bus.alu_a     = ex_a;
    assign bus.alu_b     = ex_b;
    assign bus.alu_s     = ex_s;
    assign bus.res_valid = wb_valid;
    assign bus.res_data  = wb_data;
    assign bus.res_dst   = wb_dst;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: ALU model, scoreboard queue filled at issue,
// monitor pops and compares on every res_valid && res_ready.
module tb_alu_issue_stage;
    typedef struct packed {
        logic [2:0]  dst;
        logic [15:0] data;
    } exp_t;

    localparam logic [1:0] OP_AND = 2'b00, OP_NOT = 2'b01, OP_ADD = 2'b10, OP_SAT = 2'b11;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   waits;
    int   exp_wait;
    exp_t sb[$];

    alu_issue_stage_if #(.W(16)) bus();

    alu_issue_stage #(.NREG(8), .W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference ALU: SAT is unsigned saturating add, NOT inverts b.
    logic [16:0] sum17;
    always_comb begin
        sum17 = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        case (bus.alu_s)
            OP_AND:  bus.alu_out = bus.alu_a & bus.alu_b;
            OP_NOT:  bus.alu_out = ~bus.alu_b;
            OP_ADD:  bus.alu_out = sum17[15:0];
            default: bus.alu_out = sum17[16] ? 16'hFFFF : sum17[15:0];
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", {13'd0, bus.res_dst, bus.res_data}, 32'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_data", {16'd0, bus.res_data}, {16'd0, e.data});
                chk("res_dst", {29'd0, bus.res_dst}, {29'd0, e.dst});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] d, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [15:0] exp, input bit push,
                         output int nwait);
        bit done;
        done  = 0;
        nwait = 0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_dst   = d;
        bus.in_src1  = s1;
        bus.in_src2  = s2;
        for (int n = 0; n < 16 && !done; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                if (push) sb.push_back('{dst: d, data: exp});
                done = 1;
            end else begin
                nwait++;
            end
        end
        if (!done) chk("issue_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic drain();
        for (int n = 0; n < 30 && sb.size() != 0; n++) @(negedge clk);
        chk("drain_empty", sb.size(), 32'd0);
        tick();
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d;
        tick();
        bus.ld_en = 1'b0;
    endtask

    initial begin
`ifdef ALU_ISSUE_BYPASS_EN
        exp_wait = 0;
`else
        exp_wait = 1;
`endif
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = 2'b00; bus.in_dst = 3'd0;
        bus.in_src1 = 3'd0; bus.in_src2 = 3'd0;
        bus.ld_en = 1'b0; bus.ld_addr = 3'd0; bus.ld_data = 16'd0;
        bus.res_ready = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_alu_a", {16'd0, bus.alu_a}, 32'd0);
        chk("rst_alu_s", {30'd0, bus.alu_s}, 32'd0);
        tick();
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        load(3'd1, 16'h0003);
        load(3'd2, 16'h0005);

        // ADD R3,R1,R2 then dependent NOT R4,R3
        issue(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0008, 1, waits);
        chk("add_alu_a", {16'd0, bus.alu_a}, 32'h0003);
        chk("add_alu_b", {16'd0, bus.alu_b}, 32'h0005);
        chk("add_alu_s", {30'd0, bus.alu_s}, 32'd2);
        issue(OP_NOT, 3'd4, 3'd0, 3'd3, 16'hFFF7, 1, waits);
        chk("dep_waits", waits, exp_wait);
        chk("not_alu_b", {16'd0, bus.alu_b}, 32'h0008);
        bus.in_valid = 1'b0;
        drain();

        // Backpressure: two accepted, third stalls with WB stable
        bus.res_ready = 1'b0;
        issue(OP_AND, 3'd5, 3'd1, 3'd2, 16'h0001, 1, waits);
        issue(OP_ADD, 3'd6, 3'd1, 3'd1, 16'h0006, 1, waits);
        chk("bp_second_waits", waits, 32'd0);
        bus.in_op = OP_SAT; bus.in_dst = 3'd7; bus.in_src1 = 3'd2; bus.in_src2 = 3'd2;
        @(negedge clk);
        chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("stall_res_data", {16'd0, bus.res_data}, 32'h0001);
        tick();
        @(negedge clk);
        chk("stall_in_ready2", {31'd0, bus.in_ready}, 32'd0);
        chk("stall_res_data2", {16'd0, bus.res_data}, 32'h0001);
        chk("stall_res_dst2", {29'd0, bus.res_dst}, 32'd5);
        chk("stall_alu_a", {16'd0, bus.alu_a}, 32'h0003);
        chk("stall_alu_b", {16'd0, bus.alu_b}, 32'h0003);
        tick();
        bus.res_ready = 1'b1;
        issue(OP_SAT, 3'd7, 3'd2, 3'd2, 16'h000A, 1, waits);
        bus.in_valid = 1'b0;
        drain();

        // ld_en to R3 collides with WB write of R3: pipeline wins
        issue(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0008, 1, waits);
        bus.in_valid = 1'b0;
        load(3'd3, 16'h1234);
        drain();
        issue(OP_AND, 3'd0, 3'd3, 3'd3, 16'h0008, 1, waits);
        chk("collide_alu_a", {16'd0, bus.alu_a}, 32'h0008);
        bus.in_valid = 1'b0;
        drain();

        // ld_data bypass into an accepting instruction
        bus.ld_en = 1'b1; bus.ld_addr = 3'd1; bus.ld_data = 16'h00F0;
        issue(OP_ADD, 3'd6, 3'd1, 3'd0, 16'h00F8, 1, waits);
        bus.ld_en = 1'b0;
        chk("ldbyp_alu_a", {16'd0, bus.alu_a}, 32'h00F0);
        bus.in_valid = 1'b0;
        drain();

        // Reset with EX and WB both occupied; nothing may emerge
        bus.res_ready = 1'b0;
        issue(OP_AND, 3'd5, 3'd1, 3'd2, 16'h0000, 0, waits);
        issue(OP_ADD, 3'd6, 3'd1, 3'd1, 16'h0000, 0, waits);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        chk("mrst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("mrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("mrst_alu_a", {16'd0, bus.alu_a}, 32'd0);
        chk("mrst_alu_b", {16'd0, bus.alu_b}, 32'd0);
        chk("mrst_res_data", {16'd0, bus.res_data}, 32'd0);
        chk("mrst_res_dst", {29'd0, bus.res_dst}, 32'd0);
        tick();
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        tick(); tick(); tick();
        issue(OP_ADD, 3'd7, 3'd1, 3'd2, 16'h0000, 1, waits);
        bus.in_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
